// File: rtl/axis_packetizer.sv
// AXI-Stream packetizer: registers the input stream and marks every PacketLength-th word with o_tlast.
// Define AXIS_PACKETIZER_HEADER_EN to put a header word (length, sequence number) in front of each packet.
module axis_packetizer #(
  parameter int DataWidth    = 32,
  parameter int PacketLength = 16,
  parameter int SeqWidth     = 8
) (
  input  logic                 aclk,
  input  logic                 areset,
  input  logic                 i_tvalid,
  output logic                 i_tready,
  input  logic [DataWidth-1:0] i_tdata,
  output logic                 o_tvalid,
  input  logic                 o_tready,
  output logic [DataWidth-1:0] o_tdata,
  output logic                 o_tlast,
  output logic [15:0]          pkt_count
);

  localparam int CntWidth = $clog2(PacketLength + 1);
  localparam logic [CntWidth-1:0] LastIdx = CntWidth'(PacketLength - 1);

  logic                 o_tvalid_reg, o_tvalid_next;
  logic [DataWidth-1:0] o_tdata_reg, o_tdata_next;
  logic                 o_tlast_reg, o_tlast_next;
  logic [15:0]          pkt_count_reg, pkt_count_next;
  logic [CntWidth-1:0]  wcnt_reg, wcnt_next;
  logic                 free;
  logic                 payload_load;

`ifdef AXIS_PACKETIZER_HEADER_EN
  typedef enum logic {HEADER, PAYLOAD} state_t;

  state_t               state_reg, state_next;
  logic [SeqWidth-1:0]  seq_reg, seq_next;
  logic [DataWidth-1:0] hdr_word;

  always_comb begin
    hdr_word                 = '0;
    hdr_word[15:0]           = 16'(PacketLength);
    hdr_word[16 +: SeqWidth] = seq_reg;
  end
`endif

  always_comb begin
    free           = ~o_tvalid_reg | o_tready;
    o_tvalid_next  = o_tvalid_reg & ~o_tready;
    o_tdata_next   = o_tdata_reg;
    o_tlast_next   = o_tlast_reg;
    wcnt_next      = wcnt_reg;
    pkt_count_next = pkt_count_reg + {15'd0, o_tvalid_reg & o_tready & o_tlast_reg};
`ifdef AXIS_PACKETIZER_HEADER_EN
    state_next     = state_reg;
    seq_next       = seq_reg;
    i_tready       = (state_reg == PAYLOAD) & free;
`else
    i_tready       = free;
`endif
    payload_load   = i_tvalid & i_tready;

    if (payload_load) begin
      o_tvalid_next = 1'b1;
      o_tdata_next  = i_tdata;
      if (wcnt_reg == LastIdx) begin
        o_tlast_next = 1'b1;
        wcnt_next    = '0;
`ifdef AXIS_PACKETIZER_HEADER_EN
        state_next   = HEADER;
`endif
      end else begin
        o_tlast_next = 1'b0;
        wcnt_next    = wcnt_reg + 1'b1;
      end
    end

`ifdef AXIS_PACKETIZER_HEADER_EN
    // The header is only emitted once a payload word is actually waiting.
    if (state_reg == HEADER && i_tvalid && free) begin
      o_tvalid_next = 1'b1;
      o_tdata_next  = hdr_word;
      o_tlast_next  = 1'b0;
      seq_next      = seq_reg + 1'b1;
      state_next    = PAYLOAD;
    end
`endif
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      o_tvalid_reg  <= 1'b0;
      o_tdata_reg   <= '0;
      o_tlast_reg   <= 1'b0;
      pkt_count_reg <= '0;
      wcnt_reg      <= '0;
`ifdef AXIS_PACKETIZER_HEADER_EN
      state_reg     <= HEADER;
      seq_reg       <= '0;
`endif
    end else begin
      o_tvalid_reg  <= o_tvalid_next;
      o_tdata_reg   <= o_tdata_next;
      o_tlast_reg   <= o_tlast_next;
      pkt_count_reg <= pkt_count_next;
      wcnt_reg      <= wcnt_next;
`ifdef AXIS_PACKETIZER_HEADER_EN
      state_reg     <= state_next;
      seq_reg       <= seq_next;
`endif
    end
  end

  assign o_tvalid  = o_tvalid_reg;
  assign o_tdata   = o_tdata_reg;
  assign o_tlast   = o_tlast_reg;
  assign pkt_count = pkt_count_reg;

endmodule

// File: tb/tb_axis_packetizer.sv
// Directed bench for axis_packetizer: PacketLength=4 (dut_a) and PacketLength=1 (dut_b).
// Build with AXIS_PACKETIZER_HEADER_EN defined to exercise header insertion instead.
module tb_axis_packetizer;

  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          areset = 1'b1;
  logic          i_tvalid = 1'b0;
  logic [DW-1:0] i_tdata = '0;
  logic          o_tready = 1'b1;
  logic          sel = 1'b0;

  logic          a_i_tready, a_o_tvalid, a_o_tlast;
  logic [DW-1:0] a_o_tdata;
  logic [15:0]   a_pkt_count;
  logic          b_i_tready, b_o_tvalid, b_o_tlast;
  logic [DW-1:0] b_o_tdata;
  logic [15:0]   b_pkt_count;

  logic          i_tready, o_tvalid, o_tlast;
  logic [DW-1:0] o_tdata;
  logic [15:0]   pkt_count;

  always #5 clk = ~clk;

  axis_packetizer #(.DataWidth(DW), .PacketLength(4), .SeqWidth(8)) dut_a (
    .aclk(clk), .areset(areset),
    .i_tvalid(i_tvalid), .i_tready(a_i_tready), .i_tdata(i_tdata),
    .o_tvalid(a_o_tvalid), .o_tready(o_tready), .o_tdata(a_o_tdata),
    .o_tlast(a_o_tlast), .pkt_count(a_pkt_count)
  );

  axis_packetizer #(.DataWidth(DW), .PacketLength(1), .SeqWidth(8)) dut_b (
    .aclk(clk), .areset(areset),
    .i_tvalid(i_tvalid), .i_tready(b_i_tready), .i_tdata(i_tdata),
    .o_tvalid(b_o_tvalid), .o_tready(o_tready), .o_tdata(b_o_tdata),
    .o_tlast(b_o_tlast), .pkt_count(b_pkt_count)
  );

  assign i_tready  = sel ? b_i_tready  : a_i_tready;
  assign o_tvalid  = sel ? b_o_tvalid  : a_o_tvalid;
  assign o_tdata   = sel ? b_o_tdata   : a_o_tdata;
  assign o_tlast   = sel ? b_o_tlast   : a_o_tlast;
  assign pkt_count = sel ? b_pkt_count : a_pkt_count;

  int          n_checks = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          stall_cnt = 0;
  logic [31:0] got_d[$];
  logic        got_l[$];
  int          got_c[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor, sampled mid-cycle after the stimulus has settled.
  always @(negedge clk) begin
    #2;
    if (o_tvalid && o_tready) begin
      got_d.push_back(o_tdata);
      got_l.push_back(o_tlast);
      got_c.push_back(cyc);
    end
    if (i_tvalid && !i_tready && o_tready) stall_cnt++;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, got);
    end
  endtask

  task automatic send(input logic [31:0] d);
    i_tvalid = 1'b1;
    i_tdata  = d;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      #1;
      if (i_tready) begin
        @(posedge clk);
        #1;
        i_tvalid = 1'b0;
        return;
      end
    end
    check_val("send_timeout", {31'd0, i_tready}, 32'd1);
    i_tvalid = 1'b0;
  endtask

  task automatic do_reset();
    areset   = 1'b1;
    i_tvalid = 1'b0;
    @(posedge clk);
    #1;
    areset = 1'b0;
    got_d.delete();
    got_l.delete();
    got_c.delete();
    stall_cnt = 0;
  endtask

  task automatic drain();
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic check_stream(input string tag, input logic [31:0] ed[$], input logic el[$]);
    int n;
    check_val($sformatf("%s_count", tag), got_d.size(), ed.size());
    n = (got_d.size() < ed.size()) ? got_d.size() : ed.size();
    for (int i = 0; i < n; i++) begin
      check_val($sformatf("%s_data[%0d]", tag, i), got_d[i], ed[i]);
      check_val($sformatf("%s_last[%0d]", tag, i), {31'd0, got_l[i]}, {31'd0, el[i]});
    end
  endtask

  initial begin
    logic [31:0] ed[$];
    logic        el[$];

    repeat (2) @(posedge clk);
    do_reset();
    check_val("rst_tvalid", {31'd0, o_tvalid}, 32'd0);
    check_val("rst_tlast", {31'd0, o_tlast}, 32'd0);
    check_val("rst_tdata", o_tdata, 32'd0);
    check_val("rst_pkt_count", {16'd0, pkt_count}, 32'd0);

`ifndef AXIS_PACKETIZER_HEADER_EN
    // T1: back-to-back, 3 packets of 4
    for (int i = 0; i < 12; i++) begin
      send(i);
      if (i == 0) begin
        check_val("t1_latency_tvalid", {31'd0, o_tvalid}, 32'd1);
        check_val("t1_latency_tdata", o_tdata, 32'd0);
      end
    end
    drain();
    ed.delete(); el.delete();
    for (int i = 0; i < 12; i++) begin
      ed.push_back(i);
      el.push_back((i % 4) == 3);
    end
    check_stream("t1", ed, el);
    for (int i = 1; i < got_c.size(); i++)
      check_val($sformatf("t1_gap[%0d]", i), got_c[i] - got_c[0], i);
    check_val("t1_in_stalls", stall_cnt, 32'd0);
    check_val("t1_pkt_count", {16'd0, pkt_count}, 32'd3);
    check_val("t1_drained", {31'd0, o_tvalid}, 32'd0);

    // T2: output stall while word 5 is presented
    do_reset();
    fork
      begin
        for (int i = 0; i < 12; i++) send(i);
      end
      begin : stall_blk
        bit found;
        found = 1'b0;
        for (int n = 0; n < 100 && !found; n++) begin
          @(negedge clk);
          if (o_tvalid && o_tdata == 32'd5) found = 1'b1;
        end
        check_val("t2_word5_seen", {31'd0, found}, 32'd1);
        o_tready = 1'b0;
        for (int k = 0; k < 3; k++) begin
          #1;
          check_val($sformatf("t2_hold_data[%0d]", k), o_tdata, 32'd5);
          check_val($sformatf("t2_hold_tready[%0d]", k), {31'd0, i_tready}, 32'd0);
          @(negedge clk);
        end
        o_tready = 1'b1;
      end
    join
    drain();
    check_stream("t2", ed, el);
    check_val("t2_pkt_count", {16'd0, pkt_count}, 32'd3);

    // T3: input bubble every other cycle
    do_reset();
    for (int i = 0; i < 8; i++) begin
      send(100 + i);
      @(posedge clk);
      #1;
    end
    drain();
    ed.delete(); el.delete();
    for (int i = 0; i < 8; i++) begin
      ed.push_back(100 + i);
      el.push_back(i == 3 || i == 7);
    end
    check_stream("t3", ed, el);
    check_val("t3_pkt_count", {16'd0, pkt_count}, 32'd2);

    // T4: reset two words into a packet
    send(0);
    send(1);
    do_reset();
    check_val("t4_tvalid_after_rst", {31'd0, o_tvalid}, 32'd0);
    check_val("t4_pkt_after_rst", {16'd0, pkt_count}, 32'd0);
    for (int i = 0; i < 4; i++) send(20 + i);
    drain();
    ed = {32'd20, 32'd21, 32'd22, 32'd23};
    el = {1'b0, 1'b0, 1'b0, 1'b1};
    check_stream("t4", ed, el);
    check_val("t4_pkt_count", {16'd0, pkt_count}, 32'd1);

    // T6: PacketLength=1
    sel = 1'b1;
    do_reset();
    send(32'hA);
    send(32'hB);
    send(32'hC);
    drain();
    ed = {32'hA, 32'hB, 32'hC};
    el = {1'b1, 1'b1, 1'b1};
    check_stream("t6", ed, el);
    check_val("t6_pkt_count", {16'd0, pkt_count}, 32'd3);
`else
    // T5: header insertion, PacketLength=4, SeqWidth=8
    for (int i = 0; i < 8; i++) send(i);
    drain();
    ed = {32'h00000004, 32'd0, 32'd1, 32'd2, 32'd3,
          32'h00010004, 32'd4, 32'd5, 32'd6, 32'd7};
    el = {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    check_stream("t5", ed, el);
    check_val("t5_header_stalls", stall_cnt, 32'd2);
    check_val("t5_pkt_count", {16'd0, pkt_count}, 32'd2);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
